main_fifo_demux_reader: RTL and testbench
=========================================

Name: main_fifo_demux_reader

Overview:
- Read-side controller for the main FIFO.
- Pops words from the main FIFO while it is non-empty and neither virtual-channel (VC) FIFO is paused.
- Captures each popped word one cycle after the pop and routes it to VC0 or VC1 by a class bit.
- Sits between the main FIFO read port and the two VC FIFO push ports. Flags protocol errors.

Parameters:
DATA_SIZE, 6, word width; must match the main FIFO.
VC_BIT, 5, bit index of the class bit in the word (0 = VC0, 1 = VC1); must be < DATA_SIZE.

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high reset
fifo_empty_main  in  1  main FIFO empty flag
data_demux_vc  in  DATA_SIZE  main FIFO read data; valid the cycle after pop_main
pause_vc0  in  1  VC0 almost-full backpressure
pause_vc1  in  1  VC1 almost-full backpressure
full_vc0  in  1  VC0 full
full_vc1  in  1  VC1 full
pop_main  out  1  pop request to main FIFO
push_vc0  out  1  push strobe to VC0
push_vc1  out  1  push strobe to VC1
data_vc0  out  DATA_SIZE  data to VC0
data_vc1  out  DATA_SIZE  data to VC1
demux_error  out  1  sticky error flag
demux_idle  out  1  no state change pending, nothing in flight

Behaviour:
- Reset:
  - Taken on a clk edge with reset=1.
  - All outputs go to 0, state goes to INIT, in-flight flag is cleared.
  - Reset mid-operation discards any in-flight word; no push is issued for it.
- FSM states: INIT, IDLE, RUN.
  - INIT -> IDLE unconditionally after one cycle. No pop is allowed in INIT.
  - IDLE -> RUN when cond = !fifo_empty_main && !pause_vc0 && !pause_vc1.
  - RUN -> IDLE when cond = 0.
- pop_main = cond && state != INIT. It is combinational (Mealy), so back-to-back pops are allowed, one per cycle.
- Stage 1: on each edge, inflight <= pop_main.
- Stage 2, cycle N+1 after a pop in cycle N, with inflight=1:
  - Sample data_demux_vc.
  - The target VC is selected by bit VC_BIT.
  - If the target's full_vcX=0: on the next edge push_vcX <= 1 and data_vcX <= word. The other push is 0.
  - If the target's full_vcX=1: the word is dropped, no push is issued, and demux_error <= 1.
- Latency: pop_main in cycle N gives push_vcX high in cycle N+2.
- push_vc0 and push_vc1 are registered single-cycle strobes and are never both high.
- data_vcX holds its last value when not pushing.
- A pause asserting while a word is in flight does not cancel it; the word is still delivered (pause means almost-full, not full).
- fifo_empty_main rising while a word is in flight does not cancel the capture.
- demux_error:
  - Also set if pop_main would be 1 while fifo_empty_main=1 (internal assertion; should be unreachable).
  - Sticky until reset.
- demux_idle = (state==IDLE) && !inflight && !push_vc0 && !push_vc1. It is 0 during reset and in INIT.

Optional Feature:
DEMUX_STATS_EN
- Defined: adds outputs count_vc0 and count_vc1, each 8 bits.
  - Each increments on its push_vcX and wraps 255 -> 0.
  - Both reset to 0.
  - A dropped word does not increment either count.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - FSM state encoding typedef (INIT=2'd0, IDLE=2'd1, RUN=2'd2).
  - Default DATA_SIZE and VC_BIT constants, reused by the main FIFO and VC FIFOs.
- Sub-module vc_route_stage: the stage-2 register holding data plus push, the full check and error generation. It is instantiated once.
- Top level holds the FSM and the pop logic.

Test Plan:
- Reset then idle: reset high 2 cycles, fifo_empty_main=1 -> all outputs 0, no pop in INIT, demux_idle=1 from the 2nd cycle after release.
- Single word: main FIFO holds 6'b100011, no pauses -> pop_main for 1 cycle, push_vc1=1 with data_vc1=6'b100011 two cycles later, push_vc0=0.
- Burst of 4 alternating words 6'b000001, 6'b100010, 6'b000011, 6'b100100 -> 4 consecutive pops; pushes alternate VC0/VC1 with matching data, each 2 cycles after its pop.
- Backpressure:
  - pause_vc0=1 mid-burst -> pop_main drops the same cycle.
  - The in-flight word is still pushed.
  - Popping resumes the cycle pause_vc0 returns to 0.
- Overflow: full_vc0=1 when word 6'b000101 arrives at stage 2 -> no push, demux_error=1 and stays 1 until reset.
- With DEMUX_STATS_EN: 300 pushes to VC0 -> count_vc0=44 (wrapped), count_vc1=0.

Source files
------------

// File: rtl/main_fifo_demux_reader_pkg.sv
// -----------------------------------------------------------------------------
// main_fifo_demux_reader_pkg
// Shared definitions for the main FIFO read-side demux and the FIFOs around it:
//   - state_t       : read controller FSM encoding
//   - DEF_DATA_SIZE : default word width, shared with the main and VC FIFOs
//   - DEF_VC_BIT    : default position of the class bit (0 = VC0, 1 = VC1)
// -----------------------------------------------------------------------------
package main_fifo_demux_reader_pkg;

    localparam int DEF_DATA_SIZE = 6;
    localparam int DEF_VC_BIT    = 5;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage : main_fifo_demux_reader_pkg

// File: rtl/main_fifo_demux_reader_if.sv
// -----------------------------------------------------------------------------
// main_fifo_demux_reader_if
// Bundles the main FIFO read port and the two VC FIFO push ports.
//   master : the demux reader (drives pop_main, push_vcX, data_vcX)
//   slave  : the FIFO side (drives empty/data/pause/full flags)
// Parameter DATA_SIZE : word width, must match the main FIFO.
// -----------------------------------------------------------------------------
interface main_fifo_demux_reader_if
    import main_fifo_demux_reader_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
);
    logic                 fifo_empty_main;
    logic [DATA_SIZE-1:0] data_demux_vc;
    logic                 pop_main;
    logic                 pause_vc0;
    logic                 pause_vc1;
    logic                 full_vc0;
    logic                 full_vc1;
    logic                 push_vc0;
    logic                 push_vc1;
    logic [DATA_SIZE-1:0] data_vc0;
    logic [DATA_SIZE-1:0] data_vc1;

    modport master (
        input  fifo_empty_main, data_demux_vc,
        input  pause_vc0, pause_vc1, full_vc0, full_vc1,
        output pop_main, push_vc0, push_vc1, data_vc0, data_vc1
    );

    modport slave (
        output fifo_empty_main, data_demux_vc,
        output pause_vc0, pause_vc1, full_vc0, full_vc1,
        input  pop_main, push_vc0, push_vc1, data_vc0, data_vc1
    );

endinterface : main_fifo_demux_reader_if

// File: rtl/main_fifo_demux_reader_vc_route_stage.sv
// -----------------------------------------------------------------------------
// vc_route_stage
// Stage 2 of the reader: samples the word returned by the main FIFO the cycle
// after a pop, routes it to VC0/VC1 on bit VC_BIT, and registers the push
// strobe and data. A word whose target VC is full is dropped and raises the
// sticky error flag.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   inflight            : a word popped last cycle is on data_in now
//   data_in             : main FIFO read data
//   full_vc0/full_vc1   : VC FIFO full flags
//   pop_err             : pop requested while main FIFO empty (sets error)
//   push_vc0/push_vc1   : registered single-cycle push strobes
//   data_vc0/data_vc1   : data to each VC, held between pushes
//   demux_error         : sticky error flag
// -----------------------------------------------------------------------------
module vc_route_stage #(
    parameter int DATA_SIZE = 6,
    parameter int VC_BIT    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inflight,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 full_vc0,
    input  logic                 full_vc1,
    input  logic                 pop_err,
    output logic                 push_vc0,
    output logic                 push_vc1,
    output logic [DATA_SIZE-1:0] data_vc0,
    output logic [DATA_SIZE-1:0] data_vc1,
    output logic                 demux_error
);

    logic to_vc1;
    assign to_vc1 = data_in[VC_BIT];

    // NOTE: sequential state uses <= so every register samples the pre-edge
    // values; blocking = here would let later statements see updated values.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too because they drive module
        // outputs that must read 0 after reset, not just the strobes.
        if (reset) begin
            push_vc0    <= 1'b0;
            push_vc1    <= 1'b0;
            data_vc0    <= '0;
            data_vc1    <= '0;
            demux_error <= 1'b0;
        end else begin
            push_vc0 <= 1'b0;
            push_vc1 <= 1'b0;
            if (inflight) begin
                if (to_vc1) begin
                    if (full_vc1) begin
                        demux_error <= 1'b1;
                    end else begin
                        push_vc1 <= 1'b1;
                        data_vc1 <= data_in;
                    end
                end else begin
                    if (full_vc0) begin
                        demux_error <= 1'b1;
                    end else begin
                        push_vc0 <= 1'b1;
                        data_vc0 <= data_in;
                    end
                end
            end
            if (pop_err) begin
                demux_error <= 1'b1;
            end
        end
    end

endmodule : vc_route_stage

// File: rtl/main_fifo_demux_reader.sv
// -----------------------------------------------------------------------------
// main_fifo_demux_reader
// Read-side controller for the main FIFO. Pops one word per cycle while the
// main FIFO is non-empty and neither VC is paused, then routes each popped
// word to VC0/VC1 two cycles after its pop (see vc_route_stage).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus          : main_fifo_demux_reader_if.master (FIFO read + VC push ports)
//   demux_error  : sticky protocol error flag
//   demux_idle   : IDLE state, nothing in flight, no push this cycle
//   count_vc0/1  : 8-bit wrapping push counters (only with DEMUX_STATS_EN)
// Build option: `define DEMUX_STATS_EN adds the push counters.
// -----------------------------------------------------------------------------
module main_fifo_demux_reader
    import main_fifo_demux_reader_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int VC_BIT    = DEF_VC_BIT
) (
    input  logic clk,
    input  logic reset,
    main_fifo_demux_reader_if.master bus,
    output logic demux_error,
    output logic demux_idle
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0] count_vc0,
    output logic [7:0] count_vc1
`endif
);

    state_t state, state_nxt;
    logic   cond;
    logic   pop_main;
    logic   inflight;
    logic   pop_err;

    assign cond = !bus.fifo_empty_main && !bus.pause_vc0 && !bus.pause_vc1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = IDLE;
            IDLE:    if (cond)  state_nxt = RUN;
            RUN:     if (!cond) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // Output logic. The pop is Mealy so a pop can issue every cycle; it is
    // held low during reset so no pop escapes before the state is known.
    always_comb begin
        pop_main   = cond && (state != INIT) && !reset;
        demux_idle = !reset && (state == IDLE) && !inflight
                     && !bus.push_vc0 && !bus.push_vc1;
    end

    assign bus.pop_main = pop_main;

    // Stage 1: the main FIFO returns data the cycle after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop_main;
        end
    end

    // Guard against popping an empty FIFO; cond excludes it by construction.
    assign pop_err = pop_main && bus.fifo_empty_main;

    vc_route_stage #(
        .DATA_SIZE (DATA_SIZE),
        .VC_BIT    (VC_BIT)
    ) u_route (
        .clk         (clk),
        .reset       (reset),
        .inflight    (inflight),
        .data_in     (bus.data_demux_vc),
        .full_vc0    (bus.full_vc0),
        .full_vc1    (bus.full_vc1),
        .pop_err     (pop_err),
        .push_vc0    (bus.push_vc0),
        .push_vc1    (bus.push_vc1),
        .data_vc0    (bus.data_vc0),
        .data_vc1    (bus.data_vc1),
        .demux_error (demux_error)
    );

`ifdef DEMUX_STATS_EN
    // Counters wrap naturally at 8 bits; dropped words never raise a push.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_vc0 <= 8'd0;
            count_vc1 <= 8'd0;
        end else begin
            if (bus.push_vc0) count_vc0 <= count_vc0 + 8'd1;
            if (bus.push_vc1) count_vc1 <= count_vc1 + 8'd1;
        end
    end
`endif

endmodule : main_fifo_demux_reader

// File: tb/tb_main_fifo_demux_reader.sv
// -----------------------------------------------------------------------------
// tb_main_fifo_demux_reader
// Self-checking bench: a queue stands in for the main FIFO, and a cycle-level
// reference model (expected pops, expected pushes/data, sticky error, idle and
// push counts) is compared against the DUT every cycle. Adds a table of
// single-word vectors, a burst, a backpressure sequence and random traffic.
// -----------------------------------------------------------------------------
module tb_main_fifo_demux_reader;
    import main_fifo_demux_reader_pkg::*;

    localparam int DS = DEF_DATA_SIZE;
    localparam int VB = DEF_VC_BIT;

    typedef logic [DS-1:0] word_t;

    typedef struct {
        word_t word;
        bit    f0;
        bit    f1;
        bit    exp_p0;
        bit    exp_p1;
        word_t exp_d;    // target VC data after the vector
        bit    exp_err;
    } vec_t;

    typedef struct {
        bit    vc;
        word_t d;
    } push_rec_t;

    logic clk;
    logic reset;
    logic demux_error;
    logic demux_idle;
`ifdef DEMUX_STATS_EN
    logic [7:0] count_vc0;
    logic [7:0] count_vc1;
`endif

    main_fifo_demux_reader_if #(.DATA_SIZE(DS)) bus ();

    main_fifo_demux_reader #(
        .DATA_SIZE (DS),
        .VC_BIT    (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .demux_error (demux_error),
        .demux_idle  (demux_idle)
`ifdef DEMUX_STATS_EN
        ,
        .count_vc0   (count_vc0),
        .count_vc1   (count_vc1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Main FIFO contents and a log of pushes observed on the DUT.
    word_t     fifo_q[$];
    push_rec_t push_log[$];

    // Reference model state.
    bit    m_known     = 0;  // a reset edge has been seen
    bit    m_init_done = 0;  // controller has left INIT
    bit    m_pend      = 0;  // a word was popped last cycle
    word_t m_pend_word = '0;
    bit    m_push0     = 0;
    bit    m_push1     = 0;
    word_t m_d0        = '0;
    word_t m_d1        = '0;
    bit    m_err       = 0;
    int    m_cnt0      = 0;
    int    m_cnt1      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic load(input word_t w);
        fifo_q.push_back(w);
        bus.fifo_empty_main = 1'b0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the
    // rising edge, then drive the FIFO read data just after it.
    task automatic step();
        bit    exp_pop;
        bit    f0;
        bit    f1;
        bit    exp_idle;
        word_t w;
        @(negedge clk);
        exp_pop  = !reset && m_init_done && (fifo_q.size() != 0)
                   && !bus.pause_vc0 && !bus.pause_vc1;
        exp_idle = !reset && m_init_done && !m_pend && !m_push0 && !m_push1;
        f0 = bus.full_vc0;
        f1 = bus.full_vc1;
        if (m_known) begin
            check("pop_main",    bus.pop_main, exp_pop);
            check("push_vc0",    bus.push_vc0, m_push0);
            check("push_vc1",    bus.push_vc1, m_push1);
            check("data_vc0",    bus.data_vc0, m_d0);
            check("data_vc1",    bus.data_vc1, m_d1);
            check("demux_error", demux_error,  m_err);
            check("demux_idle",  demux_idle,   exp_idle);
`ifdef DEMUX_STATS_EN
            check("count_vc0",   count_vc0,    m_cnt0);
            check("count_vc1",   count_vc1,    m_cnt1);
`endif
        end
        if (bus.push_vc0 === 1'b1) push_log.push_back('{vc: 1'b0, d: bus.data_vc0});
        if (bus.push_vc1 === 1'b1) push_log.push_back('{vc: 1'b1, d: bus.data_vc1});

        @(posedge clk);
        w = '0;
        if (reset) begin
            m_known = 1; m_init_done = 0; m_pend = 0;
            m_push0 = 0; m_push1 = 0; m_d0 = '0; m_d1 = '0;
            m_err = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            if (m_push0) m_cnt0 = (m_cnt0 + 1) % 256;
            if (m_push1) m_cnt1 = (m_cnt1 + 1) % 256;
            m_push0 = 0;
            m_push1 = 0;
            // A word popped last cycle goes to its VC unless that VC is full now.
            if (m_pend) begin
                if (m_pend_word[VB]) begin
                    if (f1) m_err = 1; else begin m_push1 = 1; m_d1 = m_pend_word; end
                end else begin
                    if (f0) m_err = 1; else begin m_push0 = 1; m_d0 = m_pend_word; end
                end
            end
            m_pend = exp_pop;
            if (exp_pop) begin
                w = fifo_q.pop_front();
                m_pend_word = w;
            end
            m_init_done = 1;
        end
        #1;
        if (exp_pop) bus.data_demux_vc = w;
        bus.fifo_empty_main = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        fifo_q.delete();
        bus.fifo_empty_main = 1'b1;
        bus.pause_vc0 = 1'b0;
        bus.pause_vc1 = 1'b0;
        bus.full_vc0  = 1'b0;
        bus.full_vc1  = 1'b0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    vec_t  vecs[6];
    word_t burst_w[4];

    initial begin
        reset = 1'b1;
        bus.fifo_empty_main = 1'b1;
        bus.data_demux_vc   = '0;
        bus.pause_vc0 = 1'b0;
        bus.pause_vc1 = 1'b0;
        bus.full_vc0  = 1'b0;
        bus.full_vc1  = 1'b0;

        //          word        f0 f1 p0 p1 exp_d       err
        vecs[0] = '{6'b100011, 0, 0, 0, 1, 6'b100011, 0};
        vecs[1] = '{6'b000101, 0, 0, 1, 0, 6'b000101, 0};
        vecs[2] = '{6'b000101, 1, 0, 0, 0, 6'b000000, 1};
        vecs[3] = '{6'b101010, 0, 1, 0, 0, 6'b000000, 1};
        vecs[4] = '{6'b111111, 1, 0, 0, 1, 6'b111111, 0};
        vecs[5] = '{6'b011110, 0, 1, 1, 0, 6'b011110, 0};
        burst_w = '{6'b000001, 6'b100010, 6'b000011, 6'b100100};

        // Reset then idle.
        do_reset(2);
        check("rst_pop",   bus.pop_main, 1'b0);
        check("rst_idle",  demux_idle,   1'b0);
        check("rst_push0", bus.push_vc0, 1'b0);
        check("rst_push1", bus.push_vc1, 1'b0);
        check("rst_data0", bus.data_vc0, 6'd0);
        check("rst_data1", bus.data_vc1, 6'd0);
        check("rst_err",   demux_error,  1'b0);
        step();
        check("idle_after_init", demux_idle, 1'b1);
        repeat (2) step();

        // Single-word vectors, including overflow drops.
        for (int i = 0; i < 6; i++) begin
            do_reset(2);
            bus.full_vc0 = vecs[i].f0;
            bus.full_vc1 = vecs[i].f1;
            load(vecs[i].word);
            repeat (3) step();  // INIT, pop, in flight
            check("vec_push0", bus.push_vc0, vecs[i].exp_p0);
            check("vec_push1", bus.push_vc1, vecs[i].exp_p1);
            check("vec_data", vecs[i].word[VB] ? bus.data_vc1 : bus.data_vc0, vecs[i].exp_d);
            check("vec_err", demux_error, vecs[i].exp_err);
            bus.full_vc0 = 1'b0;
            bus.full_vc1 = 1'b0;
            repeat (3) step();
            check("vec_err_sticky", demux_error, vecs[i].exp_err);
        end

        // Burst of four alternating words.
        do_reset(2);
        push_log.delete();
        for (int i = 0; i < 4; i++) load(burst_w[i]);
        repeat (9) step();
        check("burst_count", push_log.size(), 4);
        for (int i = 0; i < 4 && i < push_log.size(); i++) begin
            check("burst_vc",   push_log[i].vc, i % 2);
            check("burst_data", push_log[i].d,  burst_w[i]);
        end

        // Backpressure mid-burst.
        do_reset(2);
        push_log.delete();
        for (int i = 0; i < 6; i++) load(word_t'(i + 1));
        repeat (3) step();
        bus.pause_vc0 = 1'b1;
        #1;
        check("pause_pop_drop", bus.pop_main, 1'b0);
        repeat (3) step();
        bus.pause_vc0 = 1'b0;
        #1;
        check("pause_resume", bus.pop_main, 1'b1);
        repeat (8) step();
        check("pause_all_pushed", push_log.size(), 6);
        for (int i = 0; i < 6 && i < push_log.size(); i++) begin
            check("pause_data", push_log[i].d, i + 1);
        end

        // Random traffic against the model.
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) load(word_t'($urandom_range(0, 63)));
            bus.pause_vc0 = ($urandom_range(0, 7) == 0);
            bus.pause_vc1 = ($urandom_range(0, 7) == 0);
            bus.full_vc0  = ($urandom_range(0, 15) == 0);
            bus.full_vc1  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) do_reset(1);
            else step();
        end

`ifdef DEMUX_STATS_EN
        // 300 pushes to VC0 wrap the counter to 44.
        do_reset(2);
        for (int i = 0; i < 300; i++) load(word_t'(i % 32));
        repeat (310) step();
        check("stats_count_vc0", count_vc0, 8'd44);
        check("stats_count_vc1", count_vc1, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_main_fifo_demux_reader
